// File: rtl/regfile_rd2w1.sv
// regfile_rd2w1: 32 x 32-bit integer register file with two registered read
// ports and one write port. Same-edge writes bypass into the read outputs,
// x0 is hardwired to zero, and a hold input freezes the read outputs while
// writes keep landing in the array.
module regfile_rd2w1 #(
    parameter int word_width = 32,
    parameter int addr_width = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rd_req,
    input  logic [addr_width-1:0] rs1_addr,
    input  logic [addr_width-1:0] rs2_addr,
    input  logic                  hold,
    input  logic                  wren,
    input  logic [addr_width-1:0] waddr,
    input  logic [word_width-1:0] wdata,
    output logic [word_width-1:0] rs1_data,
    output logic [word_width-1:0] rs2_data,
    output logic                  rsp_valid
);

    localparam int num_regs = 2 ** addr_width;

    logic [word_width-1:0] mem_q [num_regs];
    logic [word_width-1:0] rs1_data_q, rs1_data_d;
    logic [word_width-1:0] rs2_data_q, rs2_data_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  write_hit;

    // x0 writes are dropped here so entry 0 never leaves its reset value.
    assign write_hit = wren && (waddr != '0);

    // Read value for one port: x0 reads zero, a same-edge write wins over the
    // stored contents, otherwise the array entry.
    function automatic logic [word_width-1:0] read_port(
        input logic [addr_width-1:0] addr
    );
        if (addr == '0)
            return '0;
        else if (write_hit && (waddr == addr))
            return wdata;
        else
            return mem_q[addr];
    endfunction

    // Next read-port state: hold freezes, a request loads, idle drops valid.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        rs1_data_d  = rs1_data_q;
        rs2_data_d  = rs2_data_q;
        rsp_valid_d = rsp_valid_q;
        if (!hold) begin
            if (rd_req) begin
                rs1_data_d  = read_port(rs1_addr);
                rs2_data_d  = read_port(rs2_addr);
                rsp_valid_d = 1'b1;
            end else begin
                rsp_valid_d = 1'b0;
            end
        end
    end

    // Array and output registers; reset overrides write, read and hold.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments for all state so every register
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            // NOTE: the array is built from flops and must clear on reset,
            // because unwritten registers are required to read back as zero.
            for (int i = 0; i < num_regs; i++)
                mem_q[i] <= '0;
            rs1_data_q  <= '0;
            rs2_data_q  <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            if (write_hit)
                mem_q[waddr] <= wdata;
            rs1_data_q  <= rs1_data_d;
            rs2_data_q  <= rs2_data_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign rs1_data  = rs1_data_q;
    assign rs2_data  = rs2_data_q;
    assign rsp_valid = rsp_valid_q;

endmodule

// File: tb/tb_regfile_rd2w1.sv
// Self-checking bench for regfile_rd2w1: directed steps push the expected
// post-edge outputs into a scoreboard queue, which is popped and compared
// one time unit after each rising edge.
module tb_regfile_rd2w1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rd_req = 1'b0;
    logic [4:0]  rs1_addr = '0;
    logic [4:0]  rs2_addr = '0;
    logic        hold = 1'b0;
    logic        wren = 1'b0;
    logic [4:0]  waddr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        rsp_valid;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       tag;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic        vld;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] model_mem [32];
    logic [31:0] prev_rs1 = '0;
    logic [31:0] prev_rs2 = '0;
    logic        prev_vld = 1'b0;

    regfile_rd2w1 #(.word_width(32), .addr_width(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .rd_req    (rd_req),
        .rs1_addr  (rs1_addr),
        .rs2_addr  (rs2_addr),
        .hold      (hold),
        .wren      (wren),
        .waddr     (waddr),
        .wdata     (wdata),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .rsp_valid (rsp_valid)
    );

    always #5 clk = ~clk;

    // Expected read value from the reference model, including same-edge write.
    function automatic logic [31:0] model_read(input logic [4:0] a, input logic we,
                                               input logic [4:0] wa, input logic [31:0] wd);
        if (a == 5'd0)
            return 32'h0;
        if (we && (wa == a))
            return wd;
        return model_mem[a];
    endfunction

    // Drive one cycle of stimulus, push the expected outputs, clock, then pop
    // and compare.
    task automatic step(input logic rst, input logic rd, input logic [4:0] a1,
                        input logic [4:0] a2, input logic hld, input logic we,
                        input logic [4:0] wa, input logic [31:0] wd, input string tag);
        exp_t e;
        exp_t got;
        reset = rst; rd_req = rd; rs1_addr = a1; rs2_addr = a2;
        hold = hld; wren = we; waddr = wa; wdata = wd;

        e.tag = tag;
        if (rst) begin
            e.rs1 = '0; e.rs2 = '0; e.vld = 1'b0;
            for (int i = 0; i < 32; i++) model_mem[i] = '0;
        end else begin
            if (hld) begin
                e.rs1 = prev_rs1; e.rs2 = prev_rs2; e.vld = prev_vld;
            end else if (rd) begin
                e.rs1 = model_read(a1, we, wa, wd);
                e.rs2 = model_read(a2, we, wa, wd);
                e.vld = 1'b1;
            end else begin
                e.rs1 = prev_rs1; e.rs2 = prev_rs2; e.vld = 1'b0;
            end
            if (we && (wa != 5'd0)) model_mem[wa] = wd;
        end
        prev_rs1 = e.rs1; prev_rs2 = e.rs2; prev_vld = e.vld;
        sb_q.push_back(e);

        @(posedge clk);
        #1;
        checks++;
        assert (sb_q.size() != 0) else begin
            errors++;
            $error("FAIL %s scoreboard empty: got 0 entries want 1", tag);
        end
        if (sb_q.size() != 0) begin
            got = sb_q.pop_front();
            checks++;
            assert (rs1_data === got.rs1) else begin
                errors++;
                $error("FAIL %s rs1_data: got %h want %h", got.tag, rs1_data, got.rs1);
            end
            checks++;
            assert (rs2_data === got.rs2) else begin
                errors++;
                $error("FAIL %s rs2_data: got %h want %h", got.tag, rs2_data, got.rs2);
            end
            checks++;
            assert (rsp_valid === got.vld) else begin
                errors++;
                $error("FAIL %s rsp_valid: got %b want %b", got.tag, rsp_valid, got.vld);
            end
        end
    endtask

    // Watchdog so the run always ends even if stimulus stalls.
    initial begin
        #20000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 32; i++) model_mem[i] = '0;

        //   rst rd  a1     a2     hld we  wa     wd
        step(1, 0, 5'd0,  5'd0,  0, 0, 5'd0,  32'h0,        "reset");
        step(0, 1, 5'd5,  5'd31, 0, 0, 5'd0,  32'h0,        "read_after_reset");
        step(0, 0, 5'd0,  5'd0,  0, 1, 5'd0,  32'hDEADBEEF, "write_x0");
        step(0, 1, 5'd0,  5'd0,  0, 0, 5'd0,  32'h0,        "read_x0");
        step(0, 1, 5'd0,  5'd0,  0, 1, 5'd0,  32'h5555AAAA, "x0_bypass_blocked");
        step(0, 0, 5'd0,  5'd0,  0, 1, 5'd3,  32'h12345678, "write_x3");
        step(0, 0, 5'd0,  5'd0,  0, 1, 5'd7,  32'hCAFEF00D, "write_x7");
        step(0, 1, 5'd3,  5'd7,  0, 0, 5'd0,  32'h0,        "read_x3_x7");
        step(0, 1, 5'd7,  5'd3,  0, 0, 5'd0,  32'h0,        "read_x7_x3_b2b");
        step(0, 0, 5'd0,  5'd0,  0, 1, 5'd9,  32'h00001111, "write_x9_old");
        step(0, 1, 5'd9,  5'd9,  0, 1, 5'd9,  32'hA5A5A5A5, "bypass_both");
        step(0, 1, 5'd9,  5'd0,  0, 0, 5'd0,  32'h0,        "read_x9_after");
        step(0, 1, 5'd3,  5'd12, 0, 1, 5'd12, 32'h0F0F0F0F, "bypass_port2_only");
        step(0, 1, 5'd3,  5'd3,  0, 0, 5'd0,  32'h0,        "read_x3_pre_hold");
        step(0, 1, 5'd7,  5'd9,  1, 1, 5'd3,  32'h0BADC0DE, "hold_1");
        step(0, 0, 5'd7,  5'd9,  1, 1, 5'd3,  32'h0BADC0DE, "hold_2");
        step(0, 1, 5'd3,  5'd3,  1, 1, 5'd3,  32'h0BADC0DE, "hold_3");
        step(0, 1, 5'd3,  5'd3,  0, 0, 5'd0,  32'h0,        "read_x3_after_hold");
        step(0, 0, 5'd3,  5'd3,  0, 0, 5'd0,  32'h0,        "idle_keeps_data");
        step(0, 1, 5'd4,  5'd3,  0, 1, 5'd4,  32'h0000FFFF, "reset_prep");
        step(1, 1, 5'd4,  5'd3,  0, 1, 5'd4,  32'h0000FFFF, "reset_priority");
        step(0, 1, 5'd4,  5'd3,  0, 0, 5'd0,  32'h0,        "read_x4_after_reset");
        step(0, 1, 5'd31, 5'd1,  0, 1, 5'd31, 32'h80000001, "write_x31_bypass");
        step(1, 1, 5'd31, 5'd1,  1, 0, 5'd0,  32'h0,        "reset_with_hold");
        step(0, 1, 5'd31, 5'd1,  0, 0, 5'd0,  32'h0,        "read_x31_after_reset");
        step(0, 0, 5'd0,  5'd0,  0, 0, 5'd0,  32'h0,        "final_idle");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
